// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline package: hazard FSM encoding, tag-entry record and
// stall-counter width, plus a saturating increment helper.
package fwd_hazard_ctrl_pkg;

  // Tag entries store register numbers zero-extended to this width so the
  // record type does not depend on the instantiating module's AW.
  localparam int TAG_AW_MAX  = 8;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hazState_e;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic [TAG_AW_MAX-1:0] dst;
    logic [TAG_AW_MAX-1:0] stSrc;
  } tagEntry_t;

  // Count up, sticking at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_prio_sel.sv
// Youngest-match priority select for one source operand slot.
// sel = 0 selects the register file, sel = j+1 selects tag entry j.
module fwd_prio_sel #(
  parameter int AW    = 4,
  parameter int DEPTH = 2,
  parameter int SW    = 2
) (
  input  logic [AW-1:0]       src,
  input  logic                srcUsed,
  input  logic [DEPTH-1:0]    tagValid,
  input  logic [DEPTH-1:0]    tagRegWrite,
  input  logic [DEPTH*AW-1:0] tagDst,
  output logic [SW-1:0]       sel
);

  logic [DEPTH-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gHit
      // Register 0 is hardwired zero, so a writer of R0 never forwards.
      assign hit[gi] = tagValid[gi] & tagRegWrite[gi] & srcUsed &
                       (tagDst[gi*AW +: AW] != '0) &
                       (tagDst[gi*AW +: AW] == src);
    end
  endgenerate

  // Scan oldest to youngest so the youngest (lowest index) hit is written last.
  always_comb begin
    sel = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (hit[j]) sel = SW'(j + 1);
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: tag pipeline after EX,
// per-slot forward selects, MEM-to-MEM store-data forward, stall FSM
// and a saturating stall-cycle counter.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int AW       = 4,
  parameter int NSRC     = 3,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   idex_valid_i,
  input  logic                   idex_regwrite_i,
  input  logic                   idex_memread_i,
  input  logic                   idex_memwrite_i,
  input  logic [AW-1:0]          idex_dst_i,
  input  logic [NSRC*AW-1:0]     idex_src_i,
  input  logic [NSRC-1:0]        idex_src_used_i,
  input  logic [NSRC*AW-1:0]     ifid_src_i,
  input  logic [NSRC-1:0]        ifid_src_used_i,
  output logic [NSRC*SW-1:0]     fwd_sel_o,
  output logic                   dmem_fwd_o,
  output logic                   stall_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  tagEntry_t              tagReg [DEPTH];
  tagEntry_t              tagNext;
  logic [DEPTH-1:0]       tagValid;
  logic [DEPTH-1:0]       tagRegWrite;
  logic [DEPTH*AW-1:0]    tagDst;
  logic [DEPTH-1:0]       unusedTagBits;

  hazState_e              stateReg, stateNext;
  logic [1:0]             cntReg, cntNext;
  logic                   stall;
  logic [NSRC-1:0]        ifidHit;
  logic                   loadUse;
  logic [STALL_CNT_W-1:0] stallCntReg;

  // Record entering entry 0; a stalled or flushed ID/EX becomes a bubble.
  always_comb begin
    tagNext          = '0;
    tagNext.valid    = idex_valid_i & ~flush_i & ~stall;
    tagNext.regWrite = idex_regwrite_i;
    tagNext.memRead  = idex_memread_i;
    tagNext.memWrite = idex_memwrite_i;
    tagNext.dst      = TAG_AW_MAX'(idex_dst_i);
    tagNext.stSrc    = TAG_AW_MAX'(idex_src_i[AW +: AW]);
  end

  // Tag shift pipeline: entry 0 is EX/MEM, entry DEPTH-1 the oldest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) tagReg[j] <= '0;
    end else begin
      tagReg[0] <= tagNext;
      for (int j = 1; j < DEPTH; j++) tagReg[j] <= tagReg[j-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gTagFlat
      assign tagValid[gi]          = tagReg[gi].valid;
      assign tagRegWrite[gi]       = tagReg[gi].regWrite;
      assign tagDst[gi*AW +: AW]   = tagReg[gi].dst[AW-1:0];
      // Fields kept for completeness of the record but not consumed here.
      assign unusedTagBits[gi]     = ^tagReg[gi];
    end

    for (gi = 0; gi < NSRC; gi++) begin : gSlot
      fwd_prio_sel #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SW    (SW)
      ) uPrioSel (
        .src         (idex_src_i[gi*AW +: AW]),
        .srcUsed     (idex_src_used_i[gi]),
        .tagValid    (tagValid),
        .tagRegWrite (tagRegWrite),
        .tagDst      (tagDst),
        .sel         (fwd_sel_o[gi*SW +: SW])
      );
      assign ifidHit[gi] = ifid_src_used_i[gi] &
                           (ifid_src_i[gi*AW +: AW] == idex_dst_i);
    end

    // Store in EX/MEM takes its data straight from the oldest writer.
    if (DEPTH > 1) begin : gDmem
      assign dmem_fwd_o = tagReg[0].valid & tagReg[0].memWrite &
                          tagReg[DEPTH-1].valid & tagReg[DEPTH-1].regWrite &
                          (tagReg[DEPTH-1].dst != '0) &
                          (tagReg[DEPTH-1].dst == tagReg[0].stSrc);
    end else begin : gNoDmem
      assign dmem_fwd_o = 1'b0;
    end
  endgenerate

  assign loadUse = idex_valid_i & idex_memread_i & (idex_dst_i != '0) & (|ifidHit);

  // Stall FSM next state and stall output; flush overrides any hazard.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    stall     = 1'b0;
    if (flush_i) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (stateReg)
        IDLE: begin
          stall = loadUse;
          if (loadUse && (LOAD_LAT > 1)) begin
            stateNext = HOLD;
            cntNext   = 2'(LOAD_LAT - 1);
          end
        end
        HOLD: begin
          stall   = 1'b1;
          cntNext = cntReg - 2'd1;
          if (cntReg == 2'd1) stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  // Stall FSM state and remaining-hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntReg <= '0;
    end else if (stall) begin
      stallCntReg <= satInc(stallCntReg);
    end
  end

  assign stall_o     = stall;
  assign stall_cnt_o = stallCntReg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: two instances (LOAD_LAT 1 and 3) share stimulus; the
// stimulus process queues hand-computed expectations, a monitor on the
// falling edge pops and compares them.
module tb_fwd_hazard_ctrl;

  localparam int K_FWD_A   = 0;
  localparam int K_DMEM_A  = 1;
  localparam int K_STALL_A = 2;
  localparam int K_CNT_A   = 3;
  localparam int K_STALL_B = 4;
  localparam int K_CNT_B   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        idexValid = 1'b0, idexRw = 1'b0, idexMr = 1'b0, idexMw = 1'b0;
  logic [3:0]  idexDst = '0;
  logic [11:0] idexSrc = '0;
  logic [2:0]  idexUsed = '0;
  logic [11:0] ifidSrc = '0;
  logic [2:0]  ifidUsed = '0;

  logic [5:0]  fwdSelA, fwdSelB;
  logic        dmemA, dmemB, stallA, stallB;
  logic [15:0] cntA, cntB;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;
  exp_t sbQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fwd_hazard_ctrl #(.AW(4), .NSRC(3), .DEPTH(2), .LOAD_LAT(1)) dutA (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .idex_valid_i(idexValid), .idex_regwrite_i(idexRw), .idex_memread_i(idexMr),
    .idex_memwrite_i(idexMw), .idex_dst_i(idexDst), .idex_src_i(idexSrc),
    .idex_src_used_i(idexUsed), .ifid_src_i(ifidSrc), .ifid_src_used_i(ifidUsed),
    .fwd_sel_o(fwdSelA), .dmem_fwd_o(dmemA), .stall_o(stallA), .stall_cnt_o(cntA)
  );

  fwd_hazard_ctrl #(.AW(4), .NSRC(3), .DEPTH(2), .LOAD_LAT(3)) dutB (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .idex_valid_i(idexValid), .idex_regwrite_i(idexRw), .idex_memread_i(idexMr),
    .idex_memwrite_i(idexMw), .idex_dst_i(idexDst), .idex_src_i(idexSrc),
    .idex_src_used_i(idexUsed), .ifid_src_i(ifidSrc), .ifid_src_used_i(ifidUsed),
    .fwd_sel_o(fwdSelB), .dmem_fwd_o(dmemB), .stall_o(stallB), .stall_cnt_o(cntB)
  );

  function automatic logic [15:0] actualOf(input int kind);
    case (kind)
      K_FWD_A:   return {10'd0, fwdSelA};
      K_DMEM_A:  return {15'd0, dmemA};
      K_STALL_A: return {15'd0, stallA};
      K_CNT_A:   return cntA;
      K_STALL_B: return {15'd0, stallB};
      default:   return cntB;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle on the falling edge.
  always @(negedge clk) begin
    exp_t        item;
    logic [15:0] act;
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      item = sbQ.pop_front();
      act  = actualOf(item.kind);
      checks++;
      if (item.cyc != cyc || act !== item.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d actual=%h required=%h", item.name, cyc, item.cyc, act, item.exp);
      end else begin
        $display("ok   %s cyc=%0d value=%h", item.name, cyc, act);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
    exp_t item;
    item.cyc  = cyc;
    item.kind = kind;
    item.exp  = exp;
    item.name = name;
    sbQ.push_back(item);
  endtask

  // One pipeline cycle: wait for the edge, then present ID/EX and IF/ID.
  task automatic step(input logic fl, input logic v, input logic rw, input logic mr,
                      input logic mw, input logic [3:0] dst, input logic [3:0] s0,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [2:0] used,
                      input logic [3:0] if0, input logic ifu);
    @(posedge clk);
    #1;
    flush     = fl;
    idexValid = v;
    idexRw    = rw;
    idexMr    = mr;
    idexMw    = mw;
    idexDst   = dst;
    idexSrc   = {s2, s1, s0};
    idexUsed  = used;
    ifidSrc   = {8'd0, if0};
    ifidUsed  = {2'b00, ifu};
  endtask

  task automatic expect_stall(input logic sa, input logic [15:0] ca,
                              input logic sb, input logic [15:0] cb, input string tag);
    expect_val(K_STALL_A, {15'd0, sa}, {tag, "_stallA"});
    expect_val(K_CNT_A,   ca,          {tag, "_cntA"});
    expect_val(K_STALL_B, {15'd0, sb}, {tag, "_stallB"});
    expect_val(K_CNT_B,   cb,          {tag, "_cntB"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    expect_val(K_FWD_A, 16'h0, "rst_fwd");
    expect_val(K_DMEM_A, 16'h0, "rst_dmem");
    expect_stall(0, 0, 0, 0, "rst");
    @(negedge clk); #2; rst_n = 1'b1;

    // Forwarding: ADD R3, then users of R3/R4
    step(0, 1, 1, 0, 0, 3, 1, 2, 0, 3'b011, 0, 0);
    expect_val(K_FWD_A, 16'h00, "add_r3");
    step(0, 1, 1, 0, 0, 4, 3, 1, 0, 3'b011, 0, 0);
    expect_val(K_FWD_A, 16'h01, "sub_uses_r3");
    step(0, 1, 1, 0, 0, 3, 3, 4, 3, 3'b111, 0, 0);
    expect_val(K_FWD_A, 16'h26, "three_slots");
    step(0, 1, 1, 0, 0, 3, 3, 0, 0, 3'b001, 0, 0);
    expect_val(K_FWD_A, 16'h01, "r3_in_e0");
    step(0, 1, 1, 0, 0, 0, 3, 0, 3, 3'b101, 0, 0);
    expect_val(K_FWD_A, 16'h11, "youngest_wins");
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
    expect_val(K_FWD_A, 16'h00, "r0_no_fwd");

    // MEM-to-MEM store-data forwarding
    step(0, 1, 1, 1, 0, 2, 1, 0, 0, 3'b001, 0, 0);
    expect_val(K_FWD_A, 16'h00, "ld_r2_fwd");
    expect_val(K_DMEM_A, 16'h0, "ld_r2_dmem");
    step(0, 1, 0, 0, 1, 0, 4, 2, 0, 3'b011, 0, 0);
    expect_val(K_FWD_A, 16'h04, "st_data_fwd");
    expect_val(K_DMEM_A, 16'h0, "st_in_idex_dmem");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    expect_val(K_DMEM_A, 16'h1, "dmem_r2");
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    expect_val(K_DMEM_A, 16'h0, "dmem_bubble_e0");
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 3'b010, 0, 0);
    expect_val(K_DMEM_A, 16'h0, "st_r0_idex");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    expect_val(K_DMEM_A, 16'h0, "dmem_r0");
    expect_stall(0, 0, 0, 0, "no_hazard");

    // Load-use: LD R5 with IF/ID reading R5
    step(0, 1, 1, 1, 0, 5, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(1, 0, 1, 0, "lu_c1");
    step(0, 0, 0, 0, 0, 0, 5, 0, 0, 3'b001, 5, 1);
    expect_val(K_FWD_A, 16'h00, "lu_bubble_e0");
    expect_stall(0, 1, 1, 1, "lu_c2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 1, 1, 2, "lu_c3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 1, 0, 3, "lu_c4");

    // Flush during second hold cycle
    step(0, 1, 1, 1, 0, 5, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(1, 1, 1, 3, "fl_c1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 2, 0, 4, "fl_c2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 2, 0, 4, "fl_idle");
    // Flush and hazard together resolve as flush
    step(1, 1, 1, 1, 0, 5, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 2, 0, 4, "fl_and_hz");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 2, 0, 4, "fl_after");

    // Asynchronous reset in the middle of HOLD
    step(0, 1, 1, 1, 0, 5, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(1, 2, 1, 4, "rh_c1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    expect_stall(0, 3, 1, 5, "rh_c2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5, 1);
    rst_n = 1'b0;
    expect_val(K_FWD_A, 16'h0, "rh_rst_fwd");
    expect_val(K_DMEM_A, 16'h0, "rh_rst_dmem");
    expect_stall(0, 0, 0, 0, "rh_rst");
    @(negedge clk); #2; rst_n = 1'b1;
    step(0, 1, 1, 0, 0, 3, 0, 0, 0, 3'b000, 0, 0);
    expect_stall(0, 0, 0, 0, "post_rst");
    step(0, 0, 0, 0, 0, 0, 3, 0, 0, 3'b001, 0, 0);
    expect_val(K_FWD_A, 16'h01, "post_rst_fwd");

    // Saturation: hold the hazard until the counters pass 16'hFFFE
    for (int i = 0; i < 65538; i++) begin
      step(0, 1, 1, 1, 0, 5, 0, 0, 0, 3'b000, 5, 1);
      if (i >= 65533) begin
        expect_val(K_CNT_A, (i > 65535) ? 16'hFFFF : 16'(i), "sat_cntA");
        expect_val(K_CNT_B, (i > 65535) ? 16'hFFFF : 16'(i), "sat_cntB");
        expect_val(K_STALL_A, 16'h1, "sat_stallA");
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    expect_val(K_CNT_A, 16'hFFFF, "sat_hold");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  AW  4  register address width; register 0 is hardwired zero and is never forwarded.
  NSRC  3  source operands per instruction; slot 1 carries the store-data register; NSRC >= 2.
  DEPTH  2  forwarding stages after EX (entry 0 = EX/MEM, entry DEPTH-1 = oldest); 1..4.
  LOAD_LAT  1  extra cycles before load data is forwardable; 1..3.
  Derived: SW = clog2(DEPTH+1).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  input  1  single clock; all state updates on rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  flush_i  input  1  branch/exception flush of ID/EX and earlier.
  idex_valid_i  input  1  ID/EX holds a real instruction.
  idex_regwrite_i  input  1  ID/EX instruction writes the register file.
  idex_memread_i  input  1  ID/EX instruction is a load.
  idex_memwrite_i  input  1  ID/EX instruction is a store.
  idex_dst_i  input  AW  ID/EX destination register.
  idex_src_i  input  NSRC*AW  ID/EX source registers, slot k at [k*AW +: AW].
  idex_src_used_i  input  NSRC  per-slot source-valid flags.
  ifid_src_i  input  NSRC*AW  IF/ID source registers.
  ifid_src_used_i  input  NSRC  IF/ID per-slot source-valid flags.
  fwd_sel_o  output  NSRC*SW  per-slot operand select: 0 = register file, j+1 = tag entry j.
  dmem_fwd_o  output  1  MEM-to-MEM store-data forward from the oldest entry.
  stall_o  output  1  hold PC and IF/ID; pipeline inserts a bubble into ID/EX.
  stall_cnt_o  output  16  saturating count of stall cycles.

Function
REQ-003 The block SHALL keep a DEPTH-entry tag pipeline; each entry holds {valid, regwrite, memread, memwrite, dst, stsrc}.
REQ-004 Every clock, entry j SHALL load entry j-1, and entry 0 SHALL load the ID/EX fields with valid = idex_valid_i & ~flush_i & ~stall_o; stsrc = slot 1 of idex_src_i.
REQ-005 An entry SHALL match slot k when all hold: valid, regwrite, dst != 0, dst == src_k, and src_used_k.
REQ-006 fwd_sel_o slot k SHALL be combinational and SHALL select the lowest-index (youngest) matching entry; with no match it SHALL be 0.
REQ-007 dmem_fwd_o SHALL be 1 iff entry 0 has valid & memwrite, entry DEPTH-1 has valid & regwrite, its dst != 0, and its dst == entry 0 stsrc; with DEPTH=1 it SHALL be 0.
REQ-008 Load-use hazard SHALL be flagged when idex_valid_i & idex_memread_i & idex_dst_i != 0 and idex_dst_i equals any used IF/ID source.
REQ-009 The FSM SHALL have states IDLE and HOLD plus a 2-bit counter cnt.
REQ-010 In IDLE, stall_o SHALL equal the hazard flag; on a hazard with LOAD_LAT > 1 it SHALL go to HOLD with cnt = LOAD_LAT-1.
REQ-011 In HOLD, stall_o SHALL be 1 and cnt SHALL decrement; on the cycle cnt == 1 the FSM SHALL return to IDLE.
REQ-012 flush_i SHALL override everything: stall_o = 0 that cycle and the FSM goes to IDLE; flush and hazard in the same cycle resolve as flush.
REQ-013 stall_cnt_o SHALL increment on every cycle with stall_o = 1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-014 The block SHALL add zero latency from inputs to fwd_sel_o, dmem_fwd_o and stall_o; only tag, FSM and counter state are registered.

Reset
REQ-015 While rst_n = 0, all entries SHALL be invalid, the FSM SHALL be IDLE, cnt = 0 and stall_cnt_o = 0; fwd_sel_o, dmem_fwd_o and stall_o SHALL read 0 once the input valids are 0.
REQ-016 Reset asserted mid-HOLD SHALL immediately drop stall_o; the first edge after release SHALL proceed normally.

Structure
REQ-017 The FSM state encoding, the tag-entry record type and the stall-counter width SHALL live in the shared pipeline package.
REQ-018 The per-slot youngest-match priority select SHALL be one sub-module, fwd_prio_sel, instantiated NSRC times.
REQ-019 The implementation SHALL be 120-400 lines.

Verification
REQ-020 Back-to-back ADD R3 then SUB using R3 as src0 -> fwd_sel slot0 = 1; R3 also in entry 1 -> still 1 (youngest wins).
REQ-021 Writer of R0 matching src R0 -> fwd_sel = 0 in all slots.
REQ-022 Load R5 in ID/EX, IF/ID uses R5, LOAD_LAT=1 -> stall_o high exactly 1 cycle; next cycle bubble enters entry 0 and stall_cnt_o = 1.
REQ-023 LOAD_LAT=3 with the same hazard -> stall_o high 3 cycles; flush_i during cycle 2 -> stall_o = 0 that cycle and FSM in IDLE.
REQ-024 Load R2 reaching entry 1 while store with stsrc R2 is in entry 0 (DEPTH=2) -> dmem_fwd_o = 1; R0 destination -> 0.
REQ-025 Preload stall_cnt to 16'hFFFE, apply 3 stall cycles -> saturates at 16'hFFFF; rst_n pulse mid-HOLD -> all outputs 0 asynchronously.
